dmem_port_arbiter: RTL

Arbiter and sequencer for the single-port 256x32 data memory macro in the MEM stage. It shares the memory between the pipeline load/store port and a DMA/loader port, one access per cycle. The pipeline has priority, with an optional starvation guard for DMA. It drives the macro's active-low enables, address and write data, and steers the next-cycle read data back to whichever requester issued the read.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_starve_cnt.sv | 43 ++++
 rtl/dmem_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory port arbiter: read-return owner encoding and datapath widths.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PIPE = 2'd1,
    OWN_DMA  = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_starve_cnt.sv
// Saturating DMA wait counter and force_dma compare.
// Only exists when DMEM_ARB_STARVE_GUARD_EN is defined.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_starve_cnt #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dma_req_i,
  input  logic dma_gnt_i,
  output logic force_dma_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Count waiting cycles; any grant or a dropped request restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!dma_req_i || dma_gnt_i) begin
      cnt_d = 4'd0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_dma_o = dma_req_i & (cnt_q == LIMIT);

endmodule
`endif

// File: rtl/dmem_port_arbiter.sv
// Pipeline/DMA arbiter for the single-port data memory, with next-cycle read-data steering.
// Optional DMA starvation guard: define DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = DMEM_ADDR_W
) (
  input  logic                   Clock,
  input  logic                   Reset_,
  input  logic                   PipeReq,
  input  logic                   PipeWrite,
  input  logic [ADDR_W-1:0]      PipeAddr,
  input  logic [DMEM_DATA_W-1:0] PipeWData,
  output logic                   PipeStall,
  output logic                   PipeRValid,
  output logic [DMEM_DATA_W-1:0] PipeRData,
  input  logic                   DmaReq,
  input  logic                   DmaWrite,
  input  logic [ADDR_W-1:0]      DmaAddr,
  input  logic [DMEM_DATA_W-1:0] DmaWData,
  output logic                   DmaGnt,
  output logic                   DmaRValid,
  output logic [DMEM_DATA_W-1:0] DmaRData,
  output logic                   MemCen_,
  output logic                   MemWen_,
  output logic [ADDR_W-1:0]      MemAddr,
  output logic [DMEM_DATA_W-1:0] MemD,
  input  logic [DMEM_DATA_W-1:0] MemQ
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_port_arbiter: STARVE_LIMIT must be within 1..15");
  end

  logic      force_dma;
  logic      pipe_gnt;
  logic      dma_gnt;
  rd_owner_e rd_owner_q;
  rd_owner_e rd_owner_d;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_i       (Clock),
    .rst_ni      (Reset_),
    .dma_req_i   (DmaReq),
    .dma_gnt_i   (dma_gnt),
    .force_dma_o (force_dma)
  );
`else
  assign force_dma = 1'b0;
`endif

  // Grants are qualified with Reset_ so the macro stays idle while reset is held.
  assign pipe_gnt  = Reset_ & PipeReq & ~force_dma;
  assign dma_gnt   = Reset_ & DmaReq & (~PipeReq | force_dma);
  assign PipeStall = Reset_ & PipeReq & ~pipe_gnt;
  assign DmaGnt    = dma_gnt;

  // Drive the macro from the winner and record who owns next cycle's read data.
  always_comb begin
    MemCen_    = 1'b1;
    MemWen_    = 1'b1;
    MemAddr    = '0;
    MemD       = '0;
    rd_owner_d = OWN_NONE;
    case ({pipe_gnt, dma_gnt})
      2'b10: begin
        MemCen_    = 1'b0;
        MemWen_    = ~PipeWrite;
        MemAddr    = PipeAddr;
        MemD       = PipeWData;
        rd_owner_d = PipeWrite ? OWN_NONE : OWN_PIPE;
      end
      2'b01: begin
        MemCen_    = 1'b0;
        MemWen_    = ~DmaWrite;
        MemAddr    = DmaAddr;
        MemD       = DmaWData;
        rd_owner_d = DmaWrite ? OWN_NONE : OWN_DMA;
      end
      default: begin
        MemCen_    = 1'b1;
        MemWen_    = 1'b1;
        MemAddr    = '0;
        MemD       = '0;
        rd_owner_d = OWN_NONE;
      end
    endcase
  end

  // Return owner register; reset drops any in-flight read.
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign PipeRValid = (rd_owner_q == OWN_PIPE);
  assign DmaRValid  = (rd_owner_q == OWN_DMA);
  assign PipeRData  = PipeRValid ? MemQ : '0;
  assign DmaRData   = DmaRValid ? MemQ : '0;

endmodule
